// File: rtl/muldiv_ctrl.sv
// Purpose : EX-stage multiply/divide sequencer that owns the HI/LO registers.
// Latency : MULT/MULTU stall MUL_LAT+1 cycles, DIV/DIVU stall 1+divider cycles,
//           divide-by-zero stalls 1 cycle, MTHI/MTLO never stall.
// Backpressure : stallreq holds EX until the result is in HI/LO. DONE is held
//           while ex_hold is set so the resident instruction is not reissued.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   op_valid, op, src1, src2 operation from EX (op: 1 MULT, 2 MULTU, 3 DIV,
//                            4 DIVU, 5 MTHI, 6 MTLO, other values do nothing)
//   ex_hold, flush           EX frozen by another source / annul in-flight op
//   mul_signed, mul_a, mul_b operands to the pipelined multiplier
//   mul_result               multiplier product
//   div_start, div_signed,
//   div_a, div_b, div_annul  iterative divider control and operands
//   div_result, div_ready    divider {remainder, quotient} and valid strobe
//   stallreq, busy           pipeline hold request, state != IDLE
//   hi, lo                   architectural HI/LO registers
module muldiv_ctrl #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        ex_hold,
   input  logic        flush,
   output logic        mul_signed,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_result,
   output logic        div_start,
   output logic        div_signed,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic        div_annul,
   input  logic [63:0] div_result,
   input  logic        div_ready,
   output logic        stallreq,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_WAIT = 2'd1,
      S_DIV_WAIT = 2'd2,
      S_DONE     = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_mul_a;
   logic [31:0] r_mul_b;
   logic        r_mul_signed;
   logic [31:0] r_div_a;
   logic [31:0] r_div_b;
   logic        r_div_signed;

   logic        w_is_mul;
   logic        w_is_div;
   logic        w_idle_ok;
   logic        w_acc_mul;
   logic        w_acc_div;
   logic        w_wr_hi;
   logic        w_wr_lo;
   logic        w_cap_mul;
   logic        w_cap_div;

   assign w_is_mul  = op_valid && ((op == OP_MULT) || (op == OP_MULTU));
   assign w_is_div  = op_valid && ((op == OP_DIV)  || (op == OP_DIVU));
   // Flush in IDLE kills acceptance and MTHI/MTLO writes alike.
   assign w_idle_ok = (r_state == S_IDLE) && !flush;
   assign w_acc_mul = w_idle_ok && w_is_mul;
   // Divide-by-zero never reaches the divider, so operands are not latched.
   assign w_acc_div = w_idle_ok && w_is_div && (src2 != 32'd0);
   assign w_wr_hi   = w_idle_ok && op_valid && (op == OP_MTHI);
   assign w_wr_lo   = w_idle_ok && op_valid && (op == OP_MTLO);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      stallreq     = 1'b0;
      div_start    = 1'b0;
      div_annul    = 1'b0;
      w_cap_mul    = 1'b0;
      w_cap_div    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!flush) begin
               if (w_is_mul) begin
                  stallreq     = 1'b1;
                  w_next_state = S_MUL_WAIT;
               end else if (w_is_div) begin
                  stallreq     = 1'b1;
                  w_next_state = (src2 == 32'd0) ? S_DONE : S_DIV_WAIT;
               end
            end
         end
         S_MUL_WAIT: begin
            stallreq = 1'b1;
            if (flush) begin
               w_next_state = S_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_cap_mul    = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DIV_WAIT: begin
            stallreq = 1'b1;
            if (flush) begin
               // start drops in the same cycle the abort pulse is issued
               div_annul    = 1'b1;
               w_next_state = S_IDLE;
            end else begin
               div_start = 1'b1;
               if (div_ready) begin
                  w_cap_div    = 1'b1;
                  w_next_state = S_DONE;
               end
            end
         end
         S_DONE: begin
            // EX only advances past this instruction once ex_hold is low
            if (flush || !ex_hold) begin
               w_next_state = S_IDLE;
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= 4'd0;
         r_hi         <= 32'd0;
         r_lo         <= 32'd0;
         r_mul_a      <= 32'd0;
         r_mul_b      <= 32'd0;
         r_mul_signed <= 1'b0;
         r_div_a      <= 32'd0;
         r_div_b      <= 32'd0;
         r_div_signed <= 1'b0;
      end else begin
         if (w_acc_mul) begin
            r_mul_a      <= src1;
            r_mul_b      <= src2;
            r_mul_signed <= (op == OP_MULT);
            r_cnt        <= 4'(MUL_LAT);
         end else if ((r_state == S_MUL_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_acc_div) begin
            r_div_a      <= src1;
            r_div_b      <= src2;
            r_div_signed <= (op == OP_DIV);
         end

         if (w_cap_mul) begin
            r_hi <= mul_result[63:32];
            r_lo <= mul_result[31:0];
         end else if (w_cap_div) begin
            r_hi <= div_result[63:32];
            r_lo <= div_result[31:0];
         end else begin
            if (w_wr_hi) r_hi <= src1;
            if (w_wr_lo) r_lo <= src1;
         end
      end
   end

   assign busy       = (r_state != S_IDLE);
   assign hi         = r_hi;
   assign lo         = r_lo;
   assign mul_a      = r_mul_a;
   assign mul_b      = r_mul_b;
   assign mul_signed = r_mul_signed;
   assign div_a      = r_div_a;
   assign div_b      = r_div_b;
   assign div_signed = r_div_signed;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed operations, scoreboard of expected HI/LO and
// stall lengths checked by a monitor whenever the block enters DONE.
module tb_muldiv_ctrl;
   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        ex_hold;
   logic        flush;
   logic        mul_signed;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_result;
   logic        div_start;
   logic        div_signed;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic        div_annul;
   logic [63:0] div_result;
   logic        div_ready;
   logic        stallreq;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   always #5 clk = ~clk;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src1(src1),
      .src2(src2), .ex_hold(ex_hold), .flush(flush), .mul_signed(mul_signed),
      .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
      .div_start(div_start), .div_signed(div_signed), .div_a(div_a),
      .div_b(div_b), .div_annul(div_annul), .div_result(div_result),
      .div_ready(div_ready), .stallreq(stallreq), .hi(hi), .lo(lo),
      .busy(busy)
   );

   // Multiplier model: product of the registered operands.
   assign mul_result = mul_signed ?
      ({{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b}) :
      ({32'd0, mul_a} * {32'd0, mul_b});

   // Divider model: result ready in the 33rd cycle of div_start.
   int dcnt;
   always @(posedge clk) begin
      if (rst || !div_start) dcnt <= 0;
      else                   dcnt <= dcnt + 1;
   end
   assign div_ready = div_start && (dcnt == 32);

   logic signed [31:0] sdiv_a;
   logic signed [31:0] sdiv_b;
   assign sdiv_a = div_a;
   assign sdiv_b = div_b;
   always_comb begin
      div_result = 64'd0;
      if (div_b != 32'd0) begin
         if (div_signed) div_result = {32'(sdiv_a % sdiv_b), 32'(sdiv_a / sdiv_b)};
         else            div_result = {div_a % div_b, div_a / div_b};
      end
   end

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          stall;
      int          dstarts;
      bit          chk_ms;
      logic        ms;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
      end
   endtask

   task automatic push_exp(input string nm, input logic [31:0] h, input logic [31:0] l,
                           input int st, input int ds, input bit cm, input logic m);
      exp_t e;
      e.name = nm; e.hi = h; e.lo = l; e.stall = st; e.dstarts = ds;
      e.chk_ms = cm; e.ms = m;
      sb_q.push_back(e);
   endtask

   // Monitor: counts stall and div_start cycles of the current operation and
   // checks the outcome on the first DONE cycle.
   int   mon_stall;
   int   mon_ds;
   logic mon_prev;
   initial begin : monitor
      exp_t e;
      mon_stall = 0; mon_ds = 0; mon_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mon_stall = 0; mon_ds = 0; mon_prev = 1'b0;
         end else begin
            if (stallreq)  mon_stall++;
            if (div_start) mon_ds++;
            if (busy && !stallreq && mon_prev) begin
               if (sb_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_done: hi=0x%0h lo=0x%0h with nothing expected", hi, lo);
               end else begin
                  e = sb_q.pop_front();
                  check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                  check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                  check({e.name, "_stall"}, 64'(mon_stall), 64'(e.stall));
                  check({e.name, "_divstart"}, 64'(mon_ds), 64'(e.dstarts));
                  if (e.chk_ms) check({e.name, "_mulsigned"}, 64'(mul_signed), 64'(e.ms));
               end
            end
            if (!stallreq) begin
               mon_stall = 0; mon_ds = 0;
            end
            mon_prev = stallreq;
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk); #1;
      op_valid = 1'b1; op = o; src1 = a; src2 = b;
   endtask

   task automatic wait_done(input string nm);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy && !stallreq) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL %s_timeout: no DONE state within 100 cycles", nm);
      end
   endtask

   task automatic retire_and_check_idle(input string nm);
      @(posedge clk); #1;
      op_valid = 1'b0; op = 3'd0;
      @(negedge clk);
      check({nm, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin : stim
      rst = 1'b1; op_valid = 1'b0; op = 3'd0; src1 = 32'd0; src2 = 32'd0;
      ex_hold = 1'b0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_stallreq", 64'(stallreq), 64'd0);
      check("rst_div_start", 64'(div_start), 64'd0);
      check("rst_div_annul", 64'(div_annul), 64'd0);
      check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
      check("rst_div_ab", {div_a, div_b}, 64'd0);
      check("rst_signed", 64'({mul_signed, div_signed}), 64'd0);

      // MULT -1 * 2 = -2
      push_exp("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3, 0, 1'b1, 1'b1);
      issue(3'd1, 32'hFFFF_FFFF, 32'd2);
      wait_done("mult");
      retire_and_check_idle("mult");

      // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE, then held in DONE by ex_hold
      push_exp("multu", 32'h0000_0001, 32'hFFFF_FFFE, 3, 0, 1'b1, 1'b0);
      issue(3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_done("multu");
      ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_busy", 64'(busy), 64'd1);
         check("hold_stallreq", 64'(stallreq), 64'd0);
      end
      ex_hold = 1'b0;
      retire_and_check_idle("hold");
      check("hold_hi", 64'(hi), 64'h1);

      // DIV -7 / 2: quotient -3, remainder -1
      push_exp("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 33, 1'b0, 1'b0);
      issue(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done("div");
      retire_and_check_idle("div");

      // MTHI / MTLO: no stall
      issue(3'd5, 32'h11, 32'd0);
      @(negedge clk);
      check("mthi_stallreq", 64'(stallreq), 64'd0);
      issue(3'd6, 32'h22, 32'd0);
      @(negedge clk);
      check("mthi_hi", 64'(hi), 64'h11);
      check("mtlo_stallreq", 64'(stallreq), 64'd0);
      retire_and_check_idle("mtlo");
      check("mtlo_lo", 64'(lo), 64'h22);

      // DIVU by zero: one stall cycle, no divider start, HI/LO unchanged
      push_exp("divzero", 32'h11, 32'h22, 1, 0, 1'b0, 1'b0);
      issue(3'd4, 32'd1234, 32'd0);
      wait_done("divzero");
      retire_and_check_idle("divzero");

      // DIV 100/7 flushed in its 5th DIV_WAIT cycle
      issue(3'd3, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush_annul", 64'(div_annul), 64'd1);
      check("flush_div_start", 64'(div_start), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; op_valid = 1'b0; op = 3'd0;
      @(negedge clk);
      check("flush_idle_busy", 64'(busy), 64'd0);
      check("flush_annul_once", 64'(div_annul), 64'd0);
      check("flush_hilo", {hi, lo}, {32'h11, 32'h22});
      issue(3'd6, 32'hABCD, 32'd0);
      @(negedge clk);
      check("mtlo2_stallreq", 64'(stallreq), 64'd0);
      retire_and_check_idle("mtlo2");
      check("mtlo2_hilo", {hi, lo}, {32'h11, 32'hABCD});

      // MULT 7 * -3 = -21
      push_exp("mult2", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 3, 0, 1'b1, 1'b1);
      issue(3'd1, 32'd7, 32'hFFFF_FFFD);
      wait_done("mult2");
      retire_and_check_idle("mult2");

      // DIVU 100 / 7 = 14 remainder 2
      push_exp("divu", 32'd2, 32'd14, 34, 33, 1'b0, 1'b0);
      issue(3'd4, 32'd100, 32'd7);
      wait_done("divu");
      retire_and_check_idle("divu");

      repeat (2) @(negedge clk);
      check("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
